// File: rtl/mem_copy_pkg.sv
// ============================================================================
// Module  : mem_copy_pkg
// Brief   : Shared state encoding and default widths for mem_copy_master.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mem_copy_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_copy_master.sv
// ============================================================================
// Module  : mem_copy_master
// Brief   : Word-by-word memory copy engine, 3 cycles per word (RD/WAIT/WR).
//           Optional running checksum output when MEM_COPY_CHECKSUM_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_copy_master
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    output logic              mem_start,
    output logic              mem_rwn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef MEM_COPY_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    // The captured word doubles as mem_wdata: it only changes at the end of
    // WAIT, so it naturally holds its value outside WR.
    logic [DATA_W-1:0]   data_q, data_d;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef MEM_COPY_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        addr_d    = addr_q;
        data_d    = data_q;
`ifdef MEM_COPY_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        mem_start = 1'b0;
        mem_rwn   = 1'b1;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    src_d = cmd_src;
                    dst_d = cmd_dst;
                    rem_d = cmd_len;
`ifdef MEM_COPY_CHECKSUM_EN
                    sum_d = '0;
`endif
                    if (cmd_len != '0) begin
                        state_d = ST_RD;
                        addr_d  = cmd_src;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RD: begin
                mem_start = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                data_d  = mem_rdata;
`ifdef MEM_COPY_CHECKSUM_EN
                sum_d   = sum_q + mem_rdata;
`endif
                addr_d  = dst_q;
                state_d = ST_WR;
            end
            ST_WR: begin
                mem_start = 1'b1;
                mem_rwn   = 1'b0;
                src_d     = src_q + ADDR_W'(1);
                dst_d     = dst_q + ADDR_W'(1);
                rem_d     = rem_q - LEN_W'(1);
                if (rem_q > LEN_W'(1)) begin
                    state_d = ST_RD;
                    addr_d  = src_q + ADDR_W'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;
`ifdef MEM_COPY_CHECKSUM_EN
    assign checksum  = sum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_master.sv
// ============================================================================
// Module  : tb_mem_copy_master
// Brief   : Self-checking bench: cycle-indexed transaction model plus memory
//           image reference; directed scenarios followed by random copies.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_copy_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_src = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          busy;
    logic          done;
    logic          mem_start;
    logic          mem_rwn;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    mem_copy_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .busy      (busy),
        .done      (done),
        .mem_start (mem_start),
        .mem_rwn   (mem_rwn),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
`ifdef MEM_COPY_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT (registered read) and the reference image.
    bit [DW-1:0] dmem    [0:65535];
    bit [DW-1:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (mem_start) begin
            if (mem_rwn) mem_rdata <= dmem[mem_addr];
            else         dmem[mem_addr] <= mem_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: m_k counts cycles since accept (0 = idle).
    int            m_k = 0;
    int            m_n = 0;
    int            mp, mi;
    logic [AW-1:0] m_src = '0, m_dst = '0, m_last_addr = '0, ma;
    logic [DW-1:0] m_last_wdata = '0, m_sum = '0, mv;
    bit            started = 1'b0;
    int            cyc = 0, acc_cyc = 0, lat = 0;
    int            done_cnt = 0, strobe_cnt = 0, wr_cnt = 0, busy_cnt = 0;
    logic [AW-1:0] rd_q [$];

    always @(negedge clk) begin
        cyc++;
        if (started) begin
            if (m_k == 0 || m_k == 3 * m_n + 1) begin
                chk("cmd_ready", cmd_ready, (m_k == 0));
                chk("busy", busy, (m_k != 0));
                chk("done", done, (m_k != 0));
                chk("mem_start", mem_start, 0);
                chk("mem_rwn", mem_rwn, 1);
                chk("mem_addr_hold", mem_addr, m_last_addr);
                chk("mem_wdata_hold", mem_wdata, m_last_wdata);
`ifdef MEM_COPY_CHECKSUM_EN
                chk("checksum", checksum, m_sum);
`endif
            end else begin
                mp = (m_k - 1) % 3;
                mi = (m_k - 1) / 3;
                chk("cmd_ready", cmd_ready, 0);
                chk("busy", busy, 1);
                chk("done", done, 0);
                if (mp == 0) begin
                    ma = m_src + AW'(mi);
                    chk("rd_start", mem_start, 1);
                    chk("rd_rwn", mem_rwn, 1);
                    chk("rd_addr", mem_addr, ma);
                    m_last_addr = ma;
                end else if (mp == 1) begin
                    chk("wait_start", mem_start, 0);
                    chk("wait_rwn", mem_rwn, 1);
                    chk("wait_addr", mem_addr, m_last_addr);
                    chk("wait_wdata", mem_wdata, m_last_wdata);
                end else begin
                    ma = m_dst + AW'(mi);
                    mv = ref_mem[m_src + AW'(mi)];
                    ref_mem[ma] = mv;
                    m_sum = m_sum + mv;
                    chk("wr_start", mem_start, 1);
                    chk("wr_rwn", mem_rwn, 0);
                    chk("wr_addr", mem_addr, ma);
                    chk("wr_data", mem_wdata, mv);
                    m_last_addr = ma;
                    m_last_wdata = mv;
                end
            end
            if (mem_start) strobe_cnt++;
            if (mem_start && mem_rwn) rd_q.push_back(mem_addr);
            if (mem_start && !mem_rwn) wr_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                lat = cyc - acc_cyc;
            end
        end
        if (!reset) begin
            m_k = 0;
            m_last_addr = '0;
            m_last_wdata = '0;
            m_sum = '0;
            started = 1'b1;
        end else if (started) begin
            if (m_k == 0) begin
                if (cmd_valid) begin
                    m_src = cmd_src;
                    m_dst = cmd_dst;
                    m_n = int'(cmd_len);
                    m_sum = '0;
                    m_k = 1;
                    acc_cyc = cyc;
                end
            end else if (m_k == 3 * m_n + 1) begin
                m_k = 0;
            end else begin
                m_k++;
            end
        end
    end

    task automatic set_word(input logic [AW-1:0] a, input logic [DW-1:0] v);
        dmem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic clr();
        strobe_cnt = 0;
        wr_cnt = 0;
        busy_cnt = 0;
        rd_q.delete();
    endtask

    task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_src = s;
        cmd_dst = d;
        cmd_len = n;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_src = AW'($urandom);
        cmd_dst = AW'($urandom);
        cmd_len = LW'($urandom);
    endtask

    task automatic wait_done(input int bound);
        int n;
        int start;
        n = 0;
        start = done_cnt;
        while (done_cnt == start) begin
            if (n >= bound) begin
                checks++;
                errors++;
                $display("FAIL done_timeout actual=no_done required=done_within_%0d_cycles", bound);
                return;
            end
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] s, d;
        int            n, d0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_start", mem_start, 0);
        chk("rst_mem_rwn", mem_rwn, 1);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        // Basic copy
        for (int i = 0; i < 4; i++) set_word(AW'(16'h0010 + i), 32'h0000_00A0 + i);
        clr();
        issue(16'h0010, 16'h0100, 12'd4);
        wait_done(60);
        chk("basic_latency", lat, 13);
        chk("basic_strobes", strobe_cnt, 8);
        chk("basic_busy_cycles", busy_cnt, 13);
        for (int i = 0; i < 4; i++) chk("basic_dst_word", dmem[16'h0100 + i], 32'h0000_00A0 + i);

        // Zero length
        clr();
        issue(16'h0020, 16'h0120, 12'd0);
        wait_done(20);
        chk("zero_latency", lat, 1);
        chk("zero_strobes", strobe_cnt, 0);
        chk("zero_busy_cycles", busy_cnt, 1);

        // Wrap-around
        set_word(16'hFFFE, 32'h1111_0001);
        set_word(16'hFFFF, 32'h2222_0002);
        set_word(16'h0000, 32'h3333_0003);
        clr();
        issue(16'hFFFE, 16'h0200, 12'd3);
        wait_done(40);
        chk("wrap_reads", rd_q.size(), 3);
        if (rd_q.size() == 3) begin
            chk("wrap_rd0", rd_q[0], 16'hFFFE);
            chk("wrap_rd1", rd_q[1], 16'hFFFF);
            chk("wrap_rd2", rd_q[2], 16'h0000);
        end
        chk("wrap_dst2", dmem[16'h0202], 32'h3333_0003);

        // Reset during the second write
        for (int i = 0; i < 8; i++) set_word(AW'(16'h0300 + i), $urandom);
        clr();
        d0 = done_cnt;
        issue(16'h0300, 16'h0400, 12'd8);
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_words_written", wr_cnt, 2);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_cmd_ready", cmd_ready, 1);

        // Busy rejection
        set_word(16'h0700, 32'h5A5A_5A5A);
        for (int i = 0; i < 3; i++) set_word(AW'(16'h0500 + i), $urandom);
        clr();
        d0 = done_cnt;
        issue(16'h0500, 16'h0600, 12'd3);
        @(negedge clk);
        chk("busy_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_src = 16'h0550;
        cmd_dst = 16'h0700;
        cmd_len = 12'd2;
        repeat (3) @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_done(40);
        repeat (5) @(posedge clk);
        chk("busy_done_count", done_cnt - d0, 1);
        chk("busy_second_untouched", dmem[16'h0700], 32'h5A5A_5A5A);
        chk("busy_words_written", wr_cnt, 3);

`ifdef MEM_COPY_CHECKSUM_EN
        set_word(16'h0800, 32'h0000_0001);
        set_word(16'h0801, 32'h0000_0002);
        set_word(16'h0802, 32'hFFFF_FFFF);
        issue(16'h0800, 16'h0900, 12'd3);
        wait_done(40);
        chk("checksum_literal", checksum, 32'h0000_0002);
`endif

        // Random copies, some with overlapping destination
        for (int it = 0; it < 25; it++) begin
            s = AW'($urandom);
            n = $urandom_range(0, 16);
            if (it % 3 == 0) d = s + AW'($urandom_range(1, 4));
            else             d = AW'($urandom);
            for (int i = 0; i < n; i++) set_word(s + AW'(i), $urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(s, d, LW'(n));
            wait_done(3 * n + 10);
        end

        begin
            int diffs;
            diffs = 0;
            for (int a = 0; a < 65536; a++) if (dmem[a] != ref_mem[a]) diffs++;
            chk("memory_image_diffs", diffs, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
